// File: rtl/house_hit_tracker_pkg.sv
// Shared types and constants for the election house hit tracker.
package house_hit_tracker_pkg;

  typedef enum logic [1:0] {
    Alive     = 2'd0,
    Flash     = 2'd1,
    Destroyed = 2'd2
  } house_state_t;

  // Colour value the downstream RGB mux treats as "no pixel".
  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  // Decrement that sticks at zero so hit points never wrap.
  function automatic logic [3:0] sat_dec4(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

endpackage

// File: rtl/house_hit_tracker_if.sv
// Drawing-request bus between the VGA object pipeline and the house hit tracker.
interface house_hit_tracker_if
  import house_hit_tracker_pkg::*;
#(
  parameter int unsigned NUM_BULLETS = 2
);

  logic                   startOfFrame;
  logic                   restart;
  logic                   houseDR;
  logic [NUM_BULLETS-1:0] bulletDR;

  logic                   houseHit;
  logic [NUM_BULLETS-1:0] hitMask;
  logic [3:0]             hitsLeft;
  house_state_t           houseState;
  logic                   visible;
  logic                   gameOver;

  modport master (
    output startOfFrame, restart, houseDR, bulletDR,
    input  houseHit, hitMask, hitsLeft, houseState, visible, gameOver
  );

  modport slave (
    input  startOfFrame, restart, houseDR, bulletDR,
    output houseHit, hitMask, hitsLeft, houseState, visible, gameOver
  );

endinterface

// File: rtl/house_hit_tracker_frame_event_latch.sv
// Sticky per-frame OR of an event vector. snap_o is the accumulated value; on strobe the
// latch restarts from the current event, so a same-cycle event lands in the next frame.
module house_hit_tracker_frame_event_latch #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear_i,
  input  logic             strobe_i,
  input  logic [WIDTH-1:0] event_i,
  output logic [WIDTH-1:0] snap_o
);

  logic [WIDTH-1:0] latch_d, latch_q;

  // Next latch value: clear beats strobe, strobe restarts accumulation.
  always_comb begin
    latch_d = latch_q | event_i;
    if (clear_i) begin
      latch_d = '0;
    end else if (strobe_i) begin
      latch_d = event_i;
    end
  end

  // Latch register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      latch_q <= '0;
    end else begin
      latch_q <= latch_d;
    end
  end

  assign snap_o = latch_q;

endmodule

// File: rtl/house_hit_tracker.sv
// House hit tracker: turns per-pixel house/bullet overlaps into one hit event per frame,
// and manages hit points, post-hit flashing and destruction.
module house_hit_tracker
  import house_hit_tracker_pkg::*;
#(
  parameter int unsigned NUM_BULLETS  = 2,
  parameter int unsigned MAX_HITS     = 3,
  parameter int unsigned FLASH_FRAMES = 32,
  parameter int unsigned FLASH_SHIFT  = 2
) (
  input  logic              clk,
  input  logic              resetN,
  house_hit_tracker_if.slave bus
);

  localparam logic [3:0] MaxHits4     = 4'(MAX_HITS);
  localparam logic [7:0] FlashFrames8 = 8'(FLASH_FRAMES);

  logic [NUM_BULLETS-1:0] overlap;
  logic [NUM_BULLETS-1:0] snap;

  house_state_t           state_d, state_q;
  logic [3:0]             hits_left_d, hits_left_q;
  logic [7:0]             frame_cnt_d, frame_cnt_q;
  logic                   visible_d, visible_q;
  logic                   game_over_d, game_over_q;
  logic                   house_hit_d, house_hit_q;
  logic [NUM_BULLETS-1:0] hit_mask_d, hit_mask_q;

  assign overlap = {NUM_BULLETS{bus.houseDR}} & bus.bulletDR;

  house_hit_tracker_frame_event_latch #(
    .WIDTH(NUM_BULLETS)
  ) u_latch (
    .clk      (clk),
    .resetN   (resetN),
    .clear_i  (bus.restart),
    .strobe_i (bus.startOfFrame),
    .event_i  (overlap),
    .snap_o   (snap)
  );

  // Next-state: restart dominates, otherwise evaluate the frame snapshot at frame boundaries.
  always_comb begin
    state_d     = state_q;
    hits_left_d = hits_left_q;
    frame_cnt_d = frame_cnt_q;
    visible_d   = visible_q;
    game_over_d = game_over_q;
    house_hit_d = 1'b0;
    hit_mask_d  = '0;

    if (bus.restart) begin
      state_d     = Alive;
      hits_left_d = MaxHits4;
      frame_cnt_d = 8'd0;
      visible_d   = 1'b1;
      game_over_d = 1'b0;
    end else if (bus.startOfFrame) begin
      case (state_q)
        Alive: begin
          if (|snap) begin
            house_hit_d = 1'b1;
            hit_mask_d  = snap;
            // One hit point per frame no matter how many bullets overlapped.
            hits_left_d = sat_dec4(hits_left_q);
            if (hits_left_d == 4'd0) begin
              state_d     = Destroyed;
              game_over_d = 1'b1;
              visible_d   = 1'b0;
            end else begin
              state_d     = Flash;
              frame_cnt_d = FlashFrames8;
            end
          end
        end
        Flash: begin
          frame_cnt_d = (frame_cnt_q == 8'd0) ? 8'd0 : frame_cnt_q - 8'd1;
          if (frame_cnt_d == 8'd0) begin
            state_d   = Alive;
            visible_d = 1'b1;
          end else begin
            visible_d = ~frame_cnt_d[FLASH_SHIFT];
          end
        end
        Destroyed: begin
          visible_d = 1'b0;
        end
        default: begin
          state_d = Alive;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= Alive;
      hits_left_q <= MaxHits4;
      frame_cnt_q <= 8'd0;
      visible_q   <= 1'b1;
      game_over_q <= 1'b0;
      house_hit_q <= 1'b0;
      hit_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      hits_left_q <= hits_left_d;
      frame_cnt_q <= frame_cnt_d;
      visible_q   <= visible_d;
      game_over_q <= game_over_d;
      house_hit_q <= house_hit_d;
      hit_mask_q  <= hit_mask_d;
    end
  end

  assign bus.houseHit   = house_hit_q;
  assign bus.hitMask    = hit_mask_q;
  assign bus.hitsLeft   = hits_left_q;
  assign bus.houseState = state_q;
  assign bus.visible    = visible_q;
  assign bus.gameOver   = game_over_q;

endmodule

// File: tb/tb_house_hit_tracker.sv
// Directed bench for house_hit_tracker with NUM_BULLETS=2, MAX_HITS=3, FLASH_FRAMES=32,
// FLASH_SHIFT=2.
module tb_house_hit_tracker;
  import house_hit_tracker_pkg::*;

  logic clk;
  logic resetN;
  int   checks;
  int   failures;

  house_hit_tracker_if #(.NUM_BULLETS(2)) bus ();

  house_hit_tracker #(
    .NUM_BULLETS  (2),
    .MAX_HITS     (3),
    .FLASH_FRAMES (32),
    .FLASH_SHIFT  (2)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; returns 1 time unit after the edge with inputs idle.
  task automatic step(input logic sof, input logic rst, input logic hdr, input logic [1:0] bdr);
    bus.startOfFrame = sof;
    bus.restart      = rst;
    bus.houseDR      = hdr;
    bus.bulletDR     = bdr;
    @(posedge clk);
    #1;
    bus.startOfFrame = 1'b0;
    bus.restart      = 1'b0;
    bus.houseDR      = 1'b0;
    bus.bulletDR     = 2'b00;
  endtask

  task automatic do_restart();
    step(1'b0, 1'b1, 1'b0, 2'b00);
  endtask

  // Overlap on bullet 0, then a frame boundary.
  task automatic hit_frame();
    step(1'b0, 1'b0, 1'b1, 2'b01);
    step(1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic run_out_flash();
    for (int k = 0; k < 32; k++) step(1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #12;
    checks += 6;
    if (bus.houseHit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", bus.houseHit); end
    if (bus.hitMask !== 2'b00) begin failures++; $display("FAIL reset_mask got=%b exp=00", bus.hitMask); end
    if (bus.hitsLeft !== 4'd3) begin failures++; $display("FAIL reset_hits got=%0d exp=3", bus.hitsLeft); end
    if (bus.houseState !== Alive) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.houseState); end
    if (bus.visible !== 1'b1) begin failures++; $display("FAIL reset_vis got=%b exp=1", bus.visible); end
    if (bus.gameOver !== 1'b0) begin failures++; $display("FAIL reset_go got=%b exp=0", bus.gameOver); end
    resetN = 1'b1;
  endtask

  task automatic test_single_hit();
    do_restart();
    step(1'b0, 1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    checks += 5;
    if (bus.houseHit !== 1'b1) begin failures++; $display("FAIL single_hit got=%b exp=1", bus.houseHit); end
    if (bus.hitMask !== 2'b01) begin failures++; $display("FAIL single_mask got=%b exp=01", bus.hitMask); end
    if (bus.hitsLeft !== 4'd2) begin failures++; $display("FAIL single_hits got=%0d exp=2", bus.hitsLeft); end
    if (bus.houseState !== Flash) begin failures++; $display("FAIL single_state got=%0d exp=1", bus.houseState); end
    if (bus.visible !== 1'b1) begin failures++; $display("FAIL single_vis got=%b exp=1", bus.visible); end
    step(1'b0, 1'b0, 1'b0, 2'b00);
    checks += 3;
    if (bus.houseHit !== 1'b0) begin failures++; $display("FAIL single_pulse_end got=%b exp=0", bus.houseHit); end
    if (bus.hitMask !== 2'b00) begin failures++; $display("FAIL single_mask_end got=%b exp=00", bus.hitMask); end
    if (bus.hitsLeft !== 4'd2) begin failures++; $display("FAIL single_hits_hold got=%0d exp=2", bus.hitsLeft); end
  endtask

  task automatic test_both_bullets();
    do_restart();
    step(1'b0, 1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b0, 1'b1, 2'b10);
    step(1'b0, 1'b0, 1'b1, 2'b11);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    checks += 3;
    if (bus.houseHit !== 1'b1) begin failures++; $display("FAIL both_hit got=%b exp=1", bus.houseHit); end
    if (bus.hitMask !== 2'b11) begin failures++; $display("FAIL both_mask got=%b exp=11", bus.hitMask); end
    if (bus.hitsLeft !== 4'd2) begin failures++; $display("FAIL both_hits got=%0d exp=2", bus.hitsLeft); end
    step(1'b0, 1'b0, 1'b0, 2'b00);
    checks += 1;
    if (bus.houseHit !== 1'b0) begin failures++; $display("FAIL both_single_pulse got=%b exp=0", bus.houseHit); end
  endtask

  task automatic test_flash();
    int   cnt;
    logic exp_vis;
    do_restart();
    hit_frame();
    checks += 1;
    if (bus.hitsLeft !== 4'd2) begin failures++; $display("FAIL flash_entry_hits got=%0d exp=2", bus.hitsLeft); end
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, 1'b0, 1'b1, 2'b11);
      step(1'b1, 1'b0, 1'b0, 2'b00);
      cnt     = 32 - k;
      exp_vis = (cnt == 0) ? 1'b1 : ~cnt[2];
      checks += 4;
      if (bus.houseHit !== 1'b0) begin failures++; $display("FAIL flash_hit k=%0d got=%b exp=0", k, bus.houseHit); end
      if (bus.hitsLeft !== 4'd2) begin failures++; $display("FAIL flash_hits k=%0d got=%0d exp=2", k, bus.hitsLeft); end
      if (bus.visible !== exp_vis) begin failures++; $display("FAIL flash_vis k=%0d got=%b exp=%b", k, bus.visible, exp_vis); end
      if (bus.houseState !== ((cnt == 0) ? Alive : Flash)) begin
        failures++; $display("FAIL flash_state k=%0d got=%0d", k, bus.houseState);
      end
    end
    hit_frame();
    checks += 2;
    if (bus.houseHit !== 1'b1) begin failures++; $display("FAIL flash_rehit got=%b exp=1", bus.houseHit); end
    if (bus.hitsLeft !== 4'd1) begin failures++; $display("FAIL flash_rehit_hits got=%0d exp=1", bus.hitsLeft); end
  endtask

  task automatic test_destroy();
    do_restart();
    hit_frame();
    run_out_flash();
    hit_frame();
    run_out_flash();
    hit_frame();
    checks += 5;
    if (bus.houseHit !== 1'b1) begin failures++; $display("FAIL destroy_hit got=%b exp=1", bus.houseHit); end
    if (bus.hitsLeft !== 4'd0) begin failures++; $display("FAIL destroy_hits got=%0d exp=0", bus.hitsLeft); end
    if (bus.houseState !== Destroyed) begin failures++; $display("FAIL destroy_state got=%0d exp=2", bus.houseState); end
    if (bus.gameOver !== 1'b1) begin failures++; $display("FAIL destroy_go got=%b exp=1", bus.gameOver); end
    if (bus.visible !== 1'b0) begin failures++; $display("FAIL destroy_vis got=%b exp=0", bus.visible); end
    hit_frame();
    checks += 4;
    if (bus.houseHit !== 1'b0) begin failures++; $display("FAIL dead_hit got=%b exp=0", bus.houseHit); end
    if (bus.hitsLeft !== 4'd0) begin failures++; $display("FAIL dead_hits got=%0d exp=0", bus.hitsLeft); end
    if (bus.houseState !== Destroyed) begin failures++; $display("FAIL dead_state got=%0d exp=2", bus.houseState); end
    if (bus.gameOver !== 1'b1) begin failures++; $display("FAIL dead_go got=%b exp=1", bus.gameOver); end
  endtask

  // Runs from the destroyed state left by test_destroy.
  task automatic test_restart_on_sof();
    step(1'b0, 1'b0, 1'b1, 2'b10);
    step(1'b1, 1'b1, 1'b1, 2'b01);
    checks += 5;
    if (bus.houseHit !== 1'b0) begin failures++; $display("FAIL rst_sof_hit got=%b exp=0", bus.houseHit); end
    if (bus.hitsLeft !== 4'd3) begin failures++; $display("FAIL rst_sof_hits got=%0d exp=3", bus.hitsLeft); end
    if (bus.houseState !== Alive) begin failures++; $display("FAIL rst_sof_state got=%0d exp=0", bus.houseState); end
    if (bus.gameOver !== 1'b0) begin failures++; $display("FAIL rst_sof_go got=%b exp=0", bus.gameOver); end
    if (bus.visible !== 1'b1) begin failures++; $display("FAIL rst_sof_vis got=%b exp=1", bus.visible); end
    step(1'b1, 1'b0, 1'b0, 2'b00);
    checks += 2;
    if (bus.houseHit !== 1'b0) begin failures++; $display("FAIL rst_latch_clr got=%b exp=0", bus.houseHit); end
    if (bus.hitsLeft !== 4'd3) begin failures++; $display("FAIL rst_latch_hits got=%0d exp=3", bus.hitsLeft); end
  endtask

  task automatic test_sof_overlap();
    do_restart();
    step(1'b1, 1'b0, 1'b1, 2'b10);
    checks += 2;
    if (bus.houseHit !== 1'b0) begin failures++; $display("FAIL sofov_now got=%b exp=0", bus.houseHit); end
    if (bus.hitsLeft !== 4'd3) begin failures++; $display("FAIL sofov_now_hits got=%0d exp=3", bus.hitsLeft); end
    step(1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    checks += 3;
    if (bus.houseHit !== 1'b1) begin failures++; $display("FAIL sofov_next got=%b exp=1", bus.houseHit); end
    if (bus.hitMask !== 2'b10) begin failures++; $display("FAIL sofov_mask got=%b exp=10", bus.hitMask); end
    if (bus.hitsLeft !== 4'd2) begin failures++; $display("FAIL sofov_hits got=%0d exp=2", bus.hitsLeft); end
  endtask

  task automatic test_reset_mid_flash();
    do_restart();
    hit_frame();
    step(1'b0, 1'b0, 1'b1, 2'b11);
    #2;
    resetN = 1'b0;
    #1;
    checks += 6;
    if (bus.houseHit !== 1'b0) begin failures++; $display("FAIL arst_hit got=%b exp=0", bus.houseHit); end
    if (bus.hitMask !== 2'b00) begin failures++; $display("FAIL arst_mask got=%b exp=00", bus.hitMask); end
    if (bus.hitsLeft !== 4'd3) begin failures++; $display("FAIL arst_hits got=%0d exp=3", bus.hitsLeft); end
    if (bus.houseState !== Alive) begin failures++; $display("FAIL arst_state got=%0d exp=0", bus.houseState); end
    if (bus.visible !== 1'b1) begin failures++; $display("FAIL arst_vis got=%b exp=1", bus.visible); end
    if (bus.gameOver !== 1'b0) begin failures++; $display("FAIL arst_go got=%b exp=0", bus.gameOver); end
    #1;
    resetN = 1'b1;
    step(1'b1, 1'b0, 1'b0, 2'b00);
    checks += 2;
    if (bus.houseHit !== 1'b0) begin failures++; $display("FAIL arst_spurious got=%b exp=0", bus.houseHit); end
    if (bus.hitsLeft !== 4'd3) begin failures++; $display("FAIL arst_after_hits got=%0d exp=3", bus.hitsLeft); end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    resetN           = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.restart      = 1'b0;
    bus.houseDR      = 1'b0;
    bus.bulletDR     = 2'b00;
    test_reset();
    test_single_hit();
    test_both_bullets();
    test_flash();
    test_sof_overlap();
    test_destroy();
    test_restart_on_sof();
    test_reset_mid_flash();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
